i2c_slave_reg: RTL and testbench

//  I2C slave (responder) with 7-bit address match, 8/16-bit register pointer and byte read/write
//  to a user register file. It is the far-end counterpart of our I2C master byte/top controllers,

---
 rtl/i2c_slave_reg.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_slave_reg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_reg.sv
// I2C responder: 7-bit address match, 8/16-bit register pointer, byte read/write to a user register file.
// Define I2C_SLV_AUTOINC_EN to auto-increment the register pointer after each data byte.
module i2c_slave_reg #(
  parameter int SDA_HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  input  logic [6:0]  dev_addr,
  input  logic        addr_2byte,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  output logic        busy,
  output logic [2:0]  state_o
);
`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_q, sda_q;  // [0] metastable, [1] synced, [2] history
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        rw_q, rw_d;
  logic        ack_arm_q, ack_arm_d;
  logic [7:0]  hold_q, hold_d;
  logic        oen_q, oen_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_en_q, rd_en_d;
  logic        rd_pend_q, rd_pend_d;
  logic        inc_pend_q, inc_pend_d;
  logic        busy_q, busy_d;

  logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, sda_upd, is_data;
  logic [7:0]  rx_byte;
  logic [15:0] addr_inc;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s & scl_q[2];
  assign start_det = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
  assign stop_det  = scl_s & scl_q[2] & ~sda_q[2] & sda_s;
  // SDA may only change SDA_HOLD_CYC clocks after the detected SCL fall
  assign sda_upd   = (hold_q == 8'd1);
  assign rx_byte   = {shift_q, sda_s};
  assign addr_inc  = addr_2byte ? (reg_addr_q + 16'd1) : {8'h00, reg_addr_q[7:0] + 8'h01};
  assign is_data   = addr_2byte ? (byte_idx_q == 2'd2) : (byte_idx_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      tx_q       <= 8'd0;
      byte_idx_q <= 2'd0;
      rw_q       <= 1'b0;
      ack_arm_q  <= 1'b0;
      hold_q     <= 8'd0;
      oen_q      <= 1'b1;
      reg_addr_q <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      inc_pend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= {scl_q[1:0], scl_pad_i};
      sda_q      <= {sda_q[1:0], sda_pad_i};
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      byte_idx_q <= byte_idx_d;
      rw_q       <= rw_d;
      ack_arm_q  <= ack_arm_d;
      hold_q     <= hold_d;
      oen_q      <= oen_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_pend_d;
      inc_pend_q <= inc_pend_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:     if (scl_rise && bit_cnt_q == 3'd7)
                      state_d = (shift_q == dev_addr) ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (scl_fall && ack_arm_q) state_d = rw_q ? S_TX : S_RX;
        S_RX:       if (scl_rise && bit_cnt_q == 3'd7) state_d = S_RX_ACK;
        S_RX_ACK:   if (scl_fall && ack_arm_q) state_d = S_RX;
        S_TX:       if (scl_fall && bit_cnt_q == 3'd7) state_d = S_TX_ACK;
        S_TX_ACK:   if (scl_rise && sda_s) state_d = S_IDLE;
                    else if (scl_fall && ack_arm_q) state_d = S_TX;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    byte_idx_d = byte_idx_q;
    rw_d       = rw_q;
    ack_arm_d  = ack_arm_q;
    oen_d      = oen_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_pend_d  = rd_en_q;
    inc_pend_d = 1'b0;
    hold_d     = (hold_q != 8'd0) ? hold_q - 8'd1 : 8'd0;
    if (scl_fall) hold_d = 8'(SDA_HOLD_CYC);
    if (rd_pend_q) tx_d = reg_rd_data;
    if (inc_pend_q) reg_addr_d = addr_inc;
    if (sda_upd) begin
      case (state_q)
        S_ADDR_ACK, S_RX_ACK: oen_d = 1'b0;
        S_TX:                 oen_d = tx_q[7];
        default:              oen_d = 1'b1;
      endcase
    end
    if (start_det || stop_det) begin
      oen_d     = 1'b1;
      bit_cnt_d = 3'd0;
      ack_arm_d = 1'b0;
      busy_d    = 1'b0;
      hold_d    = 8'd0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_arm_d = 1'b0;
            if (shift_q == dev_addr) begin
              busy_d = 1'b1;
              rw_d   = sda_s;
            end
          end
        end
        S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
          // first fall opens the ACK slot, second fall closes it
          if (!ack_arm_q) begin
            ack_arm_d = 1'b1;
          end else begin
            ack_arm_d = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == S_ADDR_ACK) begin
              if (rw_q) rd_en_d = 1'b1;
              else      byte_idx_d = 2'd0;
            end
          end
        end
        S_RX: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_arm_d  = 1'b0;
            byte_idx_d = (byte_idx_q == 2'd2) ? 2'd2 : byte_idx_q + 2'd1;
            if (is_data) begin
              wr_en_d    = 1'b1;
              wr_data_d  = rx_byte;
              inc_pend_d = AUTOINC;
            end else if (addr_2byte && byte_idx_q == 2'd0) begin
              reg_addr_d[15:8] = rx_byte;
            end else if (addr_2byte) begin
              reg_addr_d[7:0] = rx_byte;
            end else begin
              reg_addr_d = {8'h00, rx_byte};
            end
          end
        end
        S_TX: if (scl_fall) begin
          tx_d      = {tx_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 3'd1;
          ack_arm_d = 1'b0;
        end
        S_TX_ACK: if (scl_rise) begin
          if (sda_s) begin
            oen_d = 1'b1;
          end else begin
            ack_arm_d = 1'b1;
            if (AUTOINC) reg_addr_d = addr_inc;
          end
        end else if (scl_fall && ack_arm_q) begin
          ack_arm_d = 1'b0;
          bit_cnt_d = 3'd0;
          rd_en_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wr_en    = wr_en_q;
  assign reg_wr_data  = wr_data_q;
  assign reg_rd_en    = rd_en_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Bench for i2c_slave_reg: bit-level I2C master bus model, register-file model and write/read scoreboards.
module tb_i2c_slave_reg;
  localparam int         Q   = 8;       // clk cycles per SCL quarter period
  localparam logic [6:0] DEV = 7'h50;
`ifdef I2C_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        addr_2byte = 1'b0;
  logic [6:0]  dev_addr = DEV;
  logic        sda_pad_o, sda_padoen_o, reg_wr_en, reg_rd_en, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wr_data;
  logic [7:0]  reg_rd_data = 8'h00;
  logic [2:0]  state_o;
  logic        sda_line;

  assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

  i2c_slave_reg #(.SDA_HOLD_CYC(4)) dut (
    .clk(clk), .rst(rst), .scl_pad_i(m_scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .dev_addr(dev_addr),
    .addr_2byte(addr_2byte), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .busy(busy), .state_o(state_o)
  );

  always #10 clk = ~clk;

  // user register file attached to the DUT, and the bench's own view of it
  logic [7:0]  dmem [0:65535];
  logic [7:0]  rmem [0:65535];
  logic [23:0] exp_wr_q [$];
  logic [15:0] exp_rd_q [$];
  logic [7:0]  tx_bytes [$];
  int          checks = 0, errors = 0;
  int          wr_seen = 0, wr_exp = 0, rd_seen = 0, rd_exp = 0;
  logic [15:0] ptr = 16'h0000;
  logic        sda_low_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= dmem[reg_addr];
    if (reg_wr_en) dmem[reg_addr] = reg_wr_data;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!sda_padoen_o) sda_low_seen = 1'b1;
      if (reg_wr_en || reg_rd_en) begin
        chk("strobe_busy", 32'(busy), 32'd1);
        chk("strobe_excl", 32'(reg_wr_en & reg_rd_en), 32'd0);
      end
      if (reg_wr_en) begin
        wr_seen++;
        if (exp_wr_q.size() > 0) chk("wr", 32'({reg_addr, reg_wr_data}), 32'(exp_wr_q.pop_front()));
      end
      if (reg_rd_en) begin
        rd_seen++;
        if (exp_rd_q.size() > 0) chk("rd_addr", 32'(reg_addr), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  function automatic logic [15:0] next_ptr(input logic [15:0] p, input logic m2);
    return m2 ? p + 16'd1 : {8'h00, p[7:0] + 8'h01};
  endfunction

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); b = sda_line; q(); m_scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic send_ptr(input logic m2, input logic [15:0] p);
    logic ack;
    addr_2byte = m2;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    chk("ack_addr_w", 32'(ack), 32'd0);
    chk("busy_match", 32'(busy), 32'd1);
    if (m2) begin
      write_byte(p[15:8], ack);
      chk("ack_ptr_hi", 32'(ack), 32'd0);
    end
    write_byte(p[7:0], ack);
    chk("ack_ptr_lo", 32'(ack), 32'd0);
    ptr = m2 ? p : {8'h00, p[7:0]};
  endtask

  task automatic end_txn();
    i2c_stop(); q();
    chk("busy_after_p", 32'(busy), 32'd0);
    chk("oen_after_p", 32'(sda_padoen_o), 32'd1);
    chk("reg_addr", 32'(reg_addr), 32'(ptr));
  endtask

  // write every byte of tx_bytes starting at pointer p
  task automatic wr_txn(input logic m2, input logic [15:0] p);
    logic ack;
    send_ptr(m2, p);
    while (tx_bytes.size() > 0) begin
      logic [7:0] d;
      d = tx_bytes.pop_front();
      exp_wr_q.push_back({ptr, d});
      wr_exp++;
      rmem[ptr] = d;
      if (AUTOINC) ptr = next_ptr(ptr, m2);
      write_byte(d, ack);
      chk("ack_data", 32'(ack), 32'd0);
    end
    end_txn();
  endtask

  // random read of n bytes at p through a repeated START, last byte NACKed
  task automatic rd_txn(input logic m2, input logic [15:0] p, input int n);
    logic ack;
    logic [7:0] d;
    send_ptr(m2, p);
    i2c_start();
    exp_rd_q.push_back(ptr);
    rd_exp++;
    write_byte({DEV, 1'b1}, ack);
    chk("ack_addr_r", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(d);
      chk("rd_data", 32'(d), 32'(rmem[ptr]));
      if (i == n - 1) begin
        write_bit(1'b1);
        chk("busy_nack", 32'(busy), 32'd1);
      end else begin
        if (AUTOINC) ptr = next_ptr(ptr, m2);
        exp_rd_q.push_back(ptr);
        rd_exp++;
        write_bit(1'b0);
      end
    end
    end_txn();
  endtask

  task automatic mismatch_txn(input logic [6:0] a);
    logic ack;
    sda_low_seen = 1'b0;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    chk("ack_mismatch", 32'(ack), 32'd1);
    chk("busy_mismatch", 32'(busy), 32'd0);
    write_byte(8'($urandom), ack);
    i2c_stop(); q();
    chk("sda_never_low", 32'(sda_low_seen), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int   waited;
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_oen", 32'(sda_padoen_o), 32'd1);
    chk("rst_sda_o", 32'(sda_pad_o), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    tx_bytes = '{8'h3C};
    wr_txn(1'b0, 16'h0005);
    rd_txn(1'b1, 16'h1234, 1);
    tx_bytes = '{8'h11, 8'h22, 8'h33};
    wr_txn(1'b0, 16'h00FE);
    rd_txn(1'b0, 16'h00FE, 3);
    mismatch_txn(7'h51);

    // STOP in the middle of a data byte: no write, pointer untouched
    send_ptr(1'b0, 16'h0040);
    for (int i = 0; i < 4; i++) write_bit(1'(i & 1));
    end_txn();

    // reset while the ACK pulls SDA low
    addr_2byte = 1'b0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'({DEV, 1'b1} >> i));
    waited = 0;
    while (sda_padoen_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("ack_low_before_rst", 32'(sda_padoen_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oen", 32'(sda_padoen_o), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(reg_addr), 32'd0);
    chk("midrst_wr_data", 32'(reg_wr_data), 32'd0);
    chk("midrst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
    rst = 1'b0;
    ptr = 16'h0000;
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); q();

    for (int t = 0; t < 10; t++) begin
      logic       m2;
      logic [15:0] p;
      int         kind, n;
      m2   = 1'($urandom_range(0, 1));
      p    = 16'($urandom);
      n    = $urandom_range(1, 3);
      kind = $urandom_range(0, 5);
      if (kind < 3) begin
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
        wr_txn(m2, p);
      end else if (kind < 5) begin
        rd_txn(m2, p, n);
      end else begin
        logic [6:0] a;
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = a ^ 7'h01;
        mismatch_txn(a);
      end
    end

    repeat (4) @(negedge clk);
    chk("wr_count", 32'(wr_seen), 32'(wr_exp));
    chk("rd_count", 32'(rd_seen), 32'(rd_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
